// File: rtl/uart_pkg.sv
// Shared definitions for the UART command feeder.
//   BYTE_W  : width of a command byte
//   state_t : feeder FSM states
//   max_int : helper used to size counters
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ISSUE,
        WAIT_START,
        WAIT_END,
        GAP
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO with registered read data and a separate level counter.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, wr_data    : write request and byte (ignored while full)
//   pop, rd_data     : read request (ignored while empty); rd_data is loaded on the
//                      clock edge that accepts the pop
//   full, empty      : derived from level
//   level            : occupancy, 0 .. 2**FIFO_AW
module sync_fifo_byte
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};

    logic [BYTE_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cmd_feeder.sv
// Feeds buffered command bytes into a single-byte UART transmitter interface.
// Each issued byte is tracked through the transmitter's bps_start envelope; a
// programmable idle gap follows every frame before the next issue.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wr_en, wr_data        : push a command byte into the FIFO
//   ovf_clr               : clear the sticky overflow flag (a same-cycle overflow wins)
//   tx_bps_start          : transmitter busy envelope
//   comnd_en, comnd_data  : one-cycle issue strobe and the byte (held until next issue)
//   send_en_valid         : registered "feeder has work" indication
//   fifo_full/empty/level : FIFO status
//   byte_done             : pulse when the envelope of an issued byte falls
//   timeout_err           : pulse when the envelope never rose after an issue
//   overflow              : sticky, a write was attempted while full
module uart_tx_cmd_feeder
    import uart_pkg::*;
#(
    parameter int FIFO_AW    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int START_TO   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              ovf_clr,
    input  logic              tx_bps_start,
    output logic              comnd_en,
    output logic [BYTE_W-1:0] comnd_data,
    output logic              send_en_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              byte_done,
    output logic              timeout_err,
    output logic              overflow
);

    localparam int CNT_MAX = max_int(max_int(START_TO, GAP_CYCLES), 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter is cleared on entry, so the last waiting cycle sees value-1.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              pop;
    logic              capture;
    logic [BYTE_W-1:0] fifo_rd_data;

    sync_fifo_byte #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Saturating increment: holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pop         = 1'b0;
        capture     = 1'b0;
        comnd_en    = 1'b0;
        byte_done   = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = POP;
                end
            end
            POP: begin
                capture    = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                comnd_en   = 1'b1;
                cnt_next   = '0;
                state_next = WAIT_START;
            end
            WAIT_START: begin
                // An envelope already high (foreign frame) is taken as our start.
                if (tx_bps_start) begin
                    state_next = WAIT_END;
                end else if (cnt == START_LAST) begin
                    timeout_err = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_END: begin
                if (!tx_bps_start) begin
                    byte_done  = 1'b1;
                    cnt_next   = '0;
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            comnd_data    <= '0;
            send_en_valid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            send_en_valid <= !fifo_empty || (state != IDLE);
            if (capture) begin
                comnd_data <= fifo_rd_data;
            end
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cmd_feeder.sv
module tb_uart_tx_cmd_feeder;

    localparam int AW  = 4;
    localparam int GAP = 16;
    localparam int STO = 255;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT0: default build
    logic       wr_en, ovf_clr, tx, comnd_en, sev, full, empty, bd, to, ovf;
    logic [7:0] wr_data, comnd_data;
    logic [AW:0] level;
    // DUT1: zero-gap build
    logic       wr_en1, ovf_clr1, tx1, comnd_en1, sev1, full1, empty1, bd1, to1, ovf1;
    logic [7:0] wr_data1, comnd_data1;
    logic [AW:0] level1;

    uart_tx_cmd_feeder #(.FIFO_AW(AW), .GAP_CYCLES(GAP), .START_TO(STO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .tx_bps_start(tx), .comnd_en(comnd_en), .comnd_data(comnd_data),
        .send_en_valid(sev), .fifo_full(full), .fifo_empty(empty), .fifo_level(level),
        .byte_done(bd), .timeout_err(to), .overflow(ovf));

    uart_tx_cmd_feeder #(.FIFO_AW(AW), .GAP_CYCLES(0), .START_TO(STO)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .ovf_clr(ovf_clr1),
        .tx_bps_start(tx1), .comnd_en(comnd_en1), .comnd_data(comnd_data1),
        .send_en_valid(sev1), .fifo_full(full1), .fifo_empty(empty1), .fifo_level(level1),
        .byte_done(bd1), .timeout_err(to1), .overflow(ovf1));

    int n_cmp = 0;
    int n_err = 0;

    // Transmitter model controls: 0 = frame starts 1 cycle after comnd_en, 1 = never starts
    int tx_mode = 0;
    int len_lo  = 40;
    int len_hi  = 80;

    // Logs filled by the monitors (cycle numbers use cyc)
    logic [7:0] iss_q[$];
    int         iss_c[$];
    int         fall_c[$];
    int         bd_c[$];
    int         to_c[$];
    int         sev_fall_c[$];
    logic [7:0] iss1_q[$];
    int         iss1_c[$];
    int         fall1_c[$];
    int         bd1_c[$];

    // Transmitter models: envelope high for a random number of cycles per frame
    initial begin
        int  cnt;
        bit  arm;
        cnt = 0; arm = 0; tx = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin tx = 1'b0; fall_c.push_back(cyc); end
            end
            if (arm) begin arm = 0; tx = 1'b1; cnt = $urandom_range(len_hi, len_lo); end
            if (comnd_en && tx_mode == 0) arm = 1;
        end
    end

    initial begin
        int  cnt;
        bit  arm;
        cnt = 0; arm = 0; tx1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin tx1 = 1'b0; fall1_c.push_back(cyc); end
            end
            if (arm) begin arm = 0; tx1 = 1'b1; cnt = $urandom_range(len_hi, len_lo); end
            if (comnd_en1 && tx_mode == 0) arm = 1;
        end
    end

    // Monitors sample mid-cycle
    initial begin
        bit prev_sev;
        prev_sev = 0;
        forever begin
            @(negedge clk);
            if (comnd_en) begin iss_q.push_back(comnd_data); iss_c.push_back(cyc); end
            if (bd) bd_c.push_back(cyc);
            if (to) to_c.push_back(cyc);
            if (prev_sev && !sev) sev_fall_c.push_back(cyc);
            prev_sev = sev;
            if (comnd_en1) begin iss1_q.push_back(comnd_data1); iss1_c.push_back(cyc); end
            if (bd1) bd1_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        iss_q.delete(); iss_c.delete(); fall_c.delete(); bd_c.delete(); to_c.delete();
        sev_fall_c.delete(); iss1_q.delete(); iss1_c.delete(); fall1_c.delete(); bd1_c.delete();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    // Wait until DUT0 and its transmitter are quiet for several cycles
    task automatic wait_quiet(input int budget, input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            quiet = (!sev && !tx) ? quiet + 1 : 0;
            n++;
        end
        n_cmp++;
        if (quiet < 4) begin
            n_err++;
            $display("FAIL %s_quiet: still busy after %0d cycles, expected idle", tag, budget);
        end
        tick();
    endtask

    task automatic wait_iss(input int cnt, input int budget, input string tag);
        int n = 0;
        while (iss_q.size() < cnt && n < budget) begin @(negedge clk); n++; end
        n_cmp++;
        if (iss_q.size() < cnt) begin
            n_err++;
            $display("FAIL %s_strobe: %0d strobes seen, expected %0d", tag, iss_q.size(), cnt);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (comnd_en !== 1'b0) begin n_err++; $display("FAIL rst_comnd_en: got %b exp 0", comnd_en); end
        n_cmp++; if (comnd_data !== 8'h00) begin n_err++; $display("FAIL rst_comnd_data: got %h exp 00", comnd_data); end
        n_cmp++; if (sev !== 1'b0) begin n_err++; $display("FAIL rst_sev: got %b exp 0", sev); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b exp 0", full); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d exp 0", level); end
        n_cmp++; if (bd !== 1'b0 || to !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got bd=%b to=%b exp 0 0", bd, to); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b exp 0", ovf); end
        n_cmp++;
        if ({comnd_en1, sev1, empty1, full1, bd1, to1, ovf1} !== 7'b0010000 || level1 !== '0) begin
            n_err++;
            $display("FAIL rst_dut1: got en/sev/empty/full/bd/to/ovf=%b level=%0d exp 0010000 0",
                     {comnd_en1, sev1, empty1, full1, bd1, to1, ovf1}, level1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int c0;
        clear_logs();
        tx_mode = 0; len_lo = 500; len_hi = 500;
        c0 = cyc;
        push(8'hA5);
        @(negedge clk);
        n_cmp++; if (empty !== 1'b0 || level !== 5'd1) begin n_err++; $display("FAIL single_level: got empty=%b level=%0d exp 0 1", empty, level); end
        wait_quiet(1000, "single");
        n_cmp++; if (iss_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d strobes exp 1", iss_q.size()); end
        if (iss_q.size() == 1) begin
            n_cmp++; if (iss_q[0] !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h exp a5", iss_q[0]); end
            n_cmp++; if (iss_c[0] != c0 + 3) begin n_err++; $display("FAIL single_latency: strobe at %0d exp %0d", iss_c[0], c0 + 3); end
        end
        n_cmp++; if (bd_c.size() != 1 || fall_c.size() != 1) begin n_err++; $display("FAIL single_done_count: got bd=%0d falls=%0d exp 1 1", bd_c.size(), fall_c.size()); end
        if (bd_c.size() == 1 && fall_c.size() == 1) begin
            n_cmp++; if (bd_c[0] != fall_c[0]) begin n_err++; $display("FAIL single_done_cycle: got %0d exp %0d", bd_c[0], fall_c[0]); end
            n_cmp++;
            if (sev_fall_c.size() != 1 || sev_fall_c[0] != fall_c[0] + GAP + 2) begin
                n_err++;
                $display("FAIL single_sev_fall: got %0d falls (first at %0d) exp 1 at %0d",
                         sev_fall_c.size(), (sev_fall_c.size() > 0) ? sev_fall_c[0] : -1, fall_c[0] + GAP + 2);
            end
        end
    endtask

    task automatic test_burst_overflow();
        logic [7:0] lead;
        clear_logs();
        tx_mode = 0; len_lo = 40; len_hi = 80;
        lead = 8'($urandom);
        push(lead);
        wait_iss(1, 20, "burst_lead");
        for (int k = 1; k <= 16; k++) push(8'(k));
        @(negedge clk);
        n_cmp++; if (full !== 1'b1 || level !== 5'd16) begin n_err++; $display("FAIL burst_full: got full=%b level=%0d exp 1 16", full, level); end
        push(8'hFF);
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b1 || level !== 5'd16) begin n_err++; $display("FAIL burst_ovf_set: got ovf=%b level=%0d exp 1 16", ovf, level); end
        ovf_clr = 1'b1;
        push(8'hEE);
        ovf_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL burst_ovf_set_wins: got %b exp 1", ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL burst_ovf_clr: got %b exp 0", ovf); end
        wait_quiet(4000, "burst");
        n_cmp++; if (iss_q.size() != 17 || fall_c.size() != 17) begin n_err++; $display("FAIL burst_count: got strobes=%0d falls=%0d exp 17 17", iss_q.size(), fall_c.size()); end
        n_cmp++; if (bd_c.size() != 17) begin n_err++; $display("FAIL burst_done_count: got %0d exp 17", bd_c.size()); end
        if (iss_q.size() == 17 && fall_c.size() == 17) begin
            n_cmp++; if (iss_q[0] !== lead) begin n_err++; $display("FAIL burst_lead_data: got %h exp %h", iss_q[0], lead); end
            for (int k = 1; k <= 16; k++) begin
                n_cmp++; if (iss_q[k] !== 8'(k)) begin n_err++; $display("FAIL burst_data[%0d]: got %h exp %h", k, iss_q[k], 8'(k)); end
                n_cmp++;
                if (iss_c[k] != fall_c[k-1] + GAP + 3) begin
                    n_err++;
                    $display("FAIL burst_spacing[%0d]: strobe at %0d exp %0d", k, iss_c[k], fall_c[k-1] + GAP + 3);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] x, y;
        int n;
        clear_logs();
        tx_mode = 1; len_lo = 20; len_hi = 50;
        x = 8'($urandom); y = 8'($urandom);
        push(x); push(y);
        n = 0;
        while (to_c.size() < 1 && n < 400) begin @(negedge clk); n++; end
        tx_mode = 0;
        n_cmp++; if (to_c.size() != 1 || iss_c.size() < 1) begin n_err++; $display("FAIL timeout_seen: got %0d pulses exp 1", to_c.size()); end
        if (to_c.size() == 1 && iss_c.size() >= 1) begin
            n_cmp++; if (to_c[0] != iss_c[0] + STO) begin n_err++; $display("FAIL timeout_cycle: got %0d exp %0d", to_c[0], iss_c[0] + STO); end
        end
        tick();
        wait_quiet(400, "timeout");
        n_cmp++; if (iss_q.size() != 2) begin n_err++; $display("FAIL timeout_count: got %0d strobes exp 2", iss_q.size()); end
        if (iss_q.size() == 2 && to_c.size() == 1) begin
            n_cmp++; if (iss_q[0] !== x || iss_q[1] !== y) begin n_err++; $display("FAIL timeout_data: got %h %h exp %h %h", iss_q[0], iss_q[1], x, y); end
            n_cmp++; if (iss_c[1] != to_c[0] + 3) begin n_err++; $display("FAIL timeout_next: strobe at %0d exp %0d", iss_c[1], to_c[0] + 3); end
        end
        n_cmp++; if (bd_c.size() != 1) begin n_err++; $display("FAIL timeout_done: got %0d exp 1", bd_c.size()); end
    endtask

    task automatic test_push_pop();
        logic [7:0] a, b, c;
        int n, f;
        clear_logs();
        tx_mode = 0; len_lo = 40; len_hi = 80;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        push(a);
        n = 0;
        while (tx !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL pp_level0: got %0d exp 0", level); end
        push(b);
        @(negedge clk);
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL pp_level1: got %0d exp 1", level); end
        n = 0;
        while (fall_c.size() < 1 && n < 200) begin @(negedge clk); n++; end
        f = (fall_c.size() > 0) ? fall_c[0] : cyc;
        tick();
        while (cyc < f + GAP + 1) tick();
        @(negedge clk);
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL pp_level_pre: got %0d exp 1", level); end
        push(c);
        @(negedge clk);
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL pp_level_same: got %0d exp 1", level); end
        wait_quiet(600, "pp");
        n_cmp++;
        if (iss_q.size() != 3) begin
            n_err++; $display("FAIL pp_count: got %0d strobes exp 3", iss_q.size());
        end else if (iss_q[0] !== a || iss_q[1] !== b || iss_q[2] !== c) begin
            n_err++; $display("FAIL pp_data: got %h %h %h exp %h %h %h", iss_q[0], iss_q[1], iss_q[2], a, b, c);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] nb;
        int c0;
        clear_logs();
        tx_mode = 0; len_lo = 60; len_hi = 80;
        push(8'($urandom));
        wait_iss(1, 20, "rmid_lead");
        for (int k = 0; k < 5; k++) push(8'($urandom));
        @(negedge clk);
        n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL rmid_level: got %0d exp 5", level); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({comnd_en, sev, empty, full, bd, to, ovf} !== 7'b0010000 || level !== '0 || comnd_data !== 8'h00) begin
            n_err++;
            $display("FAIL rmid_outputs: got en/sev/empty/full/bd/to/ovf=%b level=%0d data=%h exp 0010000 0 00",
                     {comnd_en, sev, empty, full, bd, to, ovf}, level, comnd_data);
        end
        repeat (150) tick();
        n_cmp++; if (iss_q.size() != 1 || bd_c.size() != 0) begin n_err++; $display("FAIL rmid_silent: got strobes=%0d done=%0d exp 1 0", iss_q.size(), bd_c.size()); end
        nb = 8'($urandom);
        c0 = cyc;
        push(nb);
        wait_quiet(400, "rmid");
        n_cmp++;
        if (iss_q.size() != 2) begin
            n_err++; $display("FAIL rmid_new: got %0d strobes exp 2", iss_q.size());
        end else if (iss_q[1] !== nb || iss_c[1] != c0 + 3) begin
            n_err++; $display("FAIL rmid_new_data: got %h at %0d exp %h at %0d", iss_q[1], iss_c[1], nb, c0 + 3);
        end
    endtask

    task automatic test_gap0();
        logic [7:0] p, q;
        int quiet, n;
        clear_logs();
        tx_mode = 0; len_lo = 20; len_hi = 50;
        p = 8'($urandom); q = 8'($urandom);
        wr_en1 = 1'b1; wr_data1 = p; tick();
        wr_data1 = q; tick();
        wr_en1 = 1'b0;
        quiet = 0; n = 0;
        while (quiet < 4 && n < 500) begin
            @(negedge clk);
            quiet = (!sev1 && !tx1) ? quiet + 1 : 0;
            n++;
        end
        n_cmp++; if (quiet < 4) begin n_err++; $display("FAIL gap0_quiet: still busy after %0d cycles exp idle", n); end
        n_cmp++; if (iss1_q.size() != 2 || fall1_c.size() != 2) begin n_err++; $display("FAIL gap0_count: got strobes=%0d falls=%0d exp 2 2", iss1_q.size(), fall1_c.size()); end
        if (iss1_q.size() == 2 && fall1_c.size() == 2) begin
            n_cmp++; if (iss1_q[0] !== p || iss1_q[1] !== q) begin n_err++; $display("FAIL gap0_data: got %h %h exp %h %h", iss1_q[0], iss1_q[1], p, q); end
            n_cmp++; if (iss1_c[1] != fall1_c[0] + 3) begin n_err++; $display("FAIL gap0_spacing: strobe at %0d exp %0d", iss1_c[1], fall1_c[0] + 3); end
        end
        n_cmp++; if (bd1_c.size() != 2) begin n_err++; $display("FAIL gap0_done: got %0d exp 2", bd1_c.size()); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
        wr_en1 = 1'b0; wr_data1 = '0; ovf_clr1 = 1'b0;
        test_reset();
        test_single();
        test_burst_overflow();
        test_timeout();
        test_push_pop();
        test_reset_midframe();
        test_gap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
